mdu_hilo_ctrl: RTL and testbench

Multiply-unit front end and HI/LO register file for the MIPS core. Sits between the EX stage and the 4-cycle pipelined multiplier: it decodes multiply and HI/LO-move operations, launches the multiplier, and waits for its result. It then writes or accumulates that result into HI/LO, and stalls the pipeline while an operation is in flight.

---
 rtl/mdu_hilo_ctrl.sv | 146 ++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_ctrl.sv
// MDU front end: decodes multiply / HI-LO moves, launches the pipelined multiplier and owns HI/LO.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate datapath.
module mdu_hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_req,
    input  logic        flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_start,
    output logic        mul_sign,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    input  logic        mul_busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_mul_s, is_signed_s, is_mthi_s, is_mtlo_s;
    logic        accept_s;
    logic [63:0] acc_s;
`ifdef MDU_MADD_EN
    typedef enum logic [1:0] {MODE_WR = 2'd0, MODE_ADD = 2'd1, MODE_SUB = 2'd2} mode_t;
    mode_t       mode_q, mode_d, op_mode_s;
`endif

    // Operation decode
    always_comb begin
        is_mul_s    = 1'b0;
        is_signed_s = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
`ifdef MDU_MADD_EN
        op_mode_s   = MODE_WR;
`endif
        case (op)
            4'd1: begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
            4'd2: is_mul_s = 1'b1;
`ifdef MDU_MADD_EN
            4'd3: begin is_mul_s = 1'b1; is_signed_s = 1'b1; op_mode_s = MODE_ADD; end
            4'd4: begin is_mul_s = 1'b1; op_mode_s = MODE_ADD; end
            4'd5: begin is_mul_s = 1'b1; is_signed_s = 1'b1; op_mode_s = MODE_SUB; end
            4'd6: begin is_mul_s = 1'b1; op_mode_s = MODE_SUB; end
`endif
            4'd7: is_mthi_s = 1'b1;
            4'd8: is_mtlo_s = 1'b1;
            default: ;
        endcase
    end

    // Completion value: plain write, or accumulate into the current HI/LO pair
    always_comb begin
`ifdef MDU_MADD_EN
        case (mode_q)
            MODE_ADD: acc_s = {hi_q, lo_q} + mul_result;
            MODE_SUB: acc_s = {hi_q, lo_q} - mul_result;
            default:  acc_s = mul_result;
        endcase
`else
        acc_s = mul_result;
`endif
    end

    // Issue is only possible from IDLE; reset and flush suppress any launch
    assign accept_s = op_valid & ~stall & ~flush & ~reset & (state_q == ST_IDLE);

    // State and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MDU_MADD_EN
            mode_q  <= MODE_WR;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_MADD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_MADD_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = ST_WAIT;
`ifdef MDU_MADD_EN
                    mode_d  = op_mode_s;
`endif
                end else if (accept_s && is_mthi_s) begin
                    hi_d = rs_val;
                end else if (accept_s && is_mtlo_s) begin
                    lo_d = rs_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A flush discards the pending product even on its completion cycle
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!mul_busy) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = acc_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        md_busy   = (state_q == ST_WAIT);
        stall     = (op_valid | rd_req) & md_busy;
        mul_start = accept_s & is_mul_s;
        mul_sign  = is_mul_s & is_signed_s;
        mul_a     = rs_val;
        mul_b     = rt_val;
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mdu_hilo_ctrl;

`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        rd_req = 1'b0;
    logic        flush = 1'b0;
    logic        stall, md_busy, mul_start, mul_sign, mul_busy;
    logic [31:0] hi, lo, mul_a, mul_b;
    logic [63:0] mul_result;

    always #5 clk = ~clk;

    mdu_hilo_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .rd_req(rd_req), .flush(flush),
        .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo),
        .mul_start(mul_start), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_busy(mul_busy)
    );

    // 4-cycle pipelined multiplier environment model
    logic [2:0]  m_cnt = 3'd0;
    logic [63:0] m_prod = 64'd0;
    assign mul_busy   = (m_cnt != 3'd0);
    assign mul_result = m_prod;
    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt  <= 3'd4;
            m_prod <= mul_sign ? 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}))
                               : ({32'd0, mul_a} * {32'd0, mul_b});
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end
    end

    // Reference model state
    logic [31:0] r_hi = 32'd0;
    logic [31:0] r_lo = 32'd0;
    bit          r_busy = 1'b0;
    int          r_issue = 0;
    logic [3:0]  r_op = 4'd0;
    logic [63:0] r_prod = 64'd0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit is_mul_op(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd2) || (MADD && o >= 4'd3 && o <= 4'd6);
    endfunction

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint      sa, sb;
        logic [63:0] ua, ub;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        return sgn ? 64'(sa * sb) : ua * ub;
    endfunction

    task automatic run_cycle(input bit v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input bit rd, input bit fl, input bit rs);
        bit          exp_start, sgn;
        logic [63:0] acc;
        @(negedge clk);
        op_valid = v; op = o; rs_val = a; rt_val = b; rd_req = rd; flush = fl; reset = rs;
        #1;
        sgn       = (o == 4'd1) || (o == 4'd3) || (o == 4'd5);
        exp_start = v && !fl && !rs && !r_busy && is_mul_op(o);
        check_val("hi", hi, r_hi);
        check_val("lo", lo, r_lo);
        check_val("md_busy", md_busy, r_busy);
        check_val("stall", stall, (v | rd) & r_busy);
        check_val("mul_start", mul_start, exp_start);
        if (exp_start) check_val("mul_sign", mul_sign, sgn);
        check_val("mul_a", mul_a, a);
        check_val("mul_b", mul_b, b);
        @(posedge clk);
        if (rs) begin
            r_busy = 1'b0; r_hi = 32'd0; r_lo = 32'd0;
        end else if (r_busy) begin
            if (fl) r_busy = 1'b0;
            else if (cyc == r_issue + 5) begin
                acc = {r_hi, r_lo};
                if (r_op == 4'd3 || r_op == 4'd4) acc = acc + r_prod;
                else if (r_op == 4'd5 || r_op == 4'd6) acc = acc - r_prod;
                else acc = r_prod;
                {r_hi, r_lo} = acc;
                r_busy = 1'b0;
            end
        end else if (v && !fl) begin
            if (is_mul_op(o)) begin
                r_busy = 1'b1; r_issue = cyc; r_op = o; r_prod = ref_product(a, b, sgn);
            end else if (o == 4'd7) r_hi = a;
            else if (o == 4'd8) r_lo = a;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check_val("rst_hi", hi, 64'd0);
        check_val("rst_lo", lo, 64'd0);
        check_val("rst_busy", md_busy, 64'd0);

        // MULT signed: -1 * 2
        run_cycle(1'b1, 4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1'b0);
        idle(5);
        #1;
        check_val("mult_hi", hi, 64'hFFFFFFFF);
        check_val("mult_lo", lo, 64'hFFFFFFFE);

        // MULTU max * max
        run_cycle(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(5);
        #1;
        check_val("multu_hi", hi, 64'hFFFFFFFE);
        check_val("multu_lo", lo, 64'h00000001);

        // MTHI/MTLO then MADD / MSUB
        run_cycle(1'b1, 4'd7, 32'h00000001, 32'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 4'd8, 32'h00000005, 32'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 4'd3, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);
        idle(5);
        #1;
        check_val("madd_hilo", {hi, lo}, MADD ? 64'h00000001_0000000B : 64'h00000001_00000005);
        run_cycle(1'b1, 4'd5, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);
        idle(5);
        #1;
        check_val("msub_hilo", {hi, lo}, 64'h00000001_00000005);

        // MFHI stall window; op at T+3 must not be accepted
        run_cycle(1'b1, 4'd1, 32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 4'd2, 32'h00000009, 32'h00000009, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("stall_end_lo", lo, 64'h0000000C);
        idle(1);

        // Flush mid-operation, then a fresh MULT
        run_cycle(1'b1, 4'd7, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 4'd8, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 4'd1, 32'h00000007, 32'h00000009, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check_val("flush_busy", md_busy, 64'd0);
        check_val("flush_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
        run_cycle(1'b1, 4'd1, 32'h00000006, 32'h00000007, 1'b0, 1'b0, 1'b0);
        idle(5);
        #1;
        check_val("post_flush_hilo", {hi, lo}, 64'h00000000_0000002A);

        // Reset mid-operation
        run_cycle(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(6);
        #1;
        check_val("rst_mid_hilo", {hi, lo}, 64'd0);
        check_val("rst_mid_busy", md_busy, 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            run_cycle(1'($urandom % 2), 4'($urandom % 16), $urandom, $urandom,
                      ($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 200) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
